// File: rtl/ram_arb_pkg.sv
// Shared definitions for the N-channel SRAM arbiter: FSM state encoding,
// legal parameter ranges and the index-width helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam int NCH_MIN    = 2;
    localparam int NCH_MAX    = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Number of bits needed to encode n distinct values (minimum 1).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_arb_nch_if.sv
// Bundle of the requestor-side handshake and the SRAM-side bus of ram_arb_nch.
// Channel k occupies bits [k*AW +: AW] of ch_addr and [k*DW +: DW] of ch_wdata.
interface ram_arb_nch_if #(
    parameter int NCH = 3,
    parameter int AW  = 13,
    parameter int DW  = 8
);
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_rdata;
    logic              ram_ce;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic [3:0]        tst;

    // Arbiter side
    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, ram_rdata,
        output ch_ack, ch_rdata, ram_ce, ram_we, ram_addr, ram_wdata, tst
    );

    // Requestors plus RAM model side
    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, ram_rdata,
        input  ch_ack, ch_rdata, ram_ce, ram_we, ram_addr, ram_wdata, tst
    );
endinterface

// File: rtl/ram_arb_nch_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from the pointer, wrapping
// at NCH-1, and grants the first asserted request. With prio_en_i set,
// channel 0 wins outright whenever it requests.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NCH = 3,
    parameter int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    input  logic           prio_en_i,
    output logic [NCH-1:0] grant_o,
    output logic [IW-1:0]  idx_o
);

    logic found;
    int   k;

    // Priority override first, then rotating scan from the pointer
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        if (prio_en_i && req_i[0]) begin
            grant_o[0] = 1'b1;
            found      = 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                k = int'(ptr_i) + i;
                if (k >= NCH) k = k - NCH;
                if (!found && req_i[k]) begin
                    found      = 1'b1;
                    grant_o[k] = 1'b1;
                    idx_o      = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/ram_arb_nch.sv
// ram_arb_nch: arbitrates NCH req/ack channels onto one single-port
// synchronous SRAM. One transaction at a time: IDLE (arbitrate) -> ISSUE
// (ram_ce pulse) -> WAIT (reads only, RD_LAT cycles) -> ACK (one-cycle ack).
// Optional build macro RAM_ARB_PRIO0_EN: channel 0 gets absolute priority and
// does not move the round-robin pointer.
module ram_arb_nch
    import ram_arb_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int AW     = 13,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    ram_arb_nch_if.slave    bus
);

    localparam int IW = clog2(NCH);
    localparam int CW = 3;

`ifdef RAM_ARB_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("ram_arb_nch: NCH outside legal range");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("ram_arb_nch: RD_LAT outside legal range");
    end

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ram_ce_q, ram_ce_d;
    logic           ram_we_q, ram_we_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
    logic [NCH-1:0] ch_ack_q, ch_ack_d;
    logic [DW-1:0]  ch_rdata_q, ch_rdata_d;

    logic [NCH-1:0] win_grant;
    logic [IW-1:0]  win_idx;
    logic           win_we;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wdata;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req_i     (bus.ch_req),
        .ptr_i     (ptr_q),
        .prio_en_i (PRIO0),
        .grant_o   (win_grant),
        .idx_o     (win_idx)
    );

    // Select the winning channel's command fields
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (win_idx == IW'(k)) begin
                win_we    = bus.ch_we[k];
                win_addr  = bus.ch_addr[k*AW +: AW];
                win_wdata = bus.ch_wdata[k*DW +: DW];
            end
        end
    end

    // Next-state and registered-output logic of the transaction FSM
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ch_ack_d    = '0;
        ch_rdata_d  = ch_rdata_q;
        case (state_q)
            IDLE: begin
                // The RAM command is registered here so ram_ce is high in ISSUE
                if (|win_grant) begin
                    gidx_d      = win_idx;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = win_we;
                    ram_addr_d  = win_addr;
                    ram_wdata_d = win_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_we_q) begin
                    ch_ack_d = NCH'(1) << gidx_q;
                    state_d  = ACK;
                end else begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    ch_rdata_d = bus.ram_rdata;
                    ch_ack_d   = NCH'(1) << gidx_q;
                    state_d    = ACK;
                end
            end
            ACK: begin
                // A priority grant of channel 0 leaves the rotation untouched
                if (!(PRIO0 && gidx_q == '0)) begin
                    ptr_d = (gidx_q == IW'(NCH - 1)) ? '0 : gidx_q + IW'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ch_ack_q    <= '0;
            ch_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ch_ack_q    <= ch_ack_d;
            ch_rdata_q  <= ch_rdata_d;
        end
    end

    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ch_ack    = ch_ack_q;
    assign bus.ch_rdata  = ch_rdata_q;
    assign bus.tst       = 4'({gidx_q, state_q});

endmodule

// File: tb/tb_ram_arb_nch.sv
// Directed bench for ram_arb_nch (NCH=3, AW=13, DW=8, RD_LAT=2) with a
// behavioural SRAM whose read data appears two cycles after the ce cycle.
module tb_ram_arb_nch;

    localparam int NCH    = 3;
    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RD_LAT-1];

    ram_arb_nch_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    ram_arb_nch #(
        .NCH    (NCH),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write on ce&we, read data delayed RD_LAT cycles after ce
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            rd_pipe[0] <= mem[bus.ram_addr];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_rdata = rd_pipe[RD_LAT-1];

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ch_we[k]              = we;
        bus.ch_addr[k*AW +: AW]   = a;
        bus.ch_wdata[k*DW +: DW]  = d;
    endtask

    // Tick until an ack appears (bounded); returns channel index and cycles taken
    task automatic wait_ack(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (bus.ch_ack != '0) break;
        end
        if (bus.ch_ack == '0) begin
            check_vec("ack_timeout", 32'(bus.ch_ack), 32'h1);
        end else begin
            check_vec("ack_onehot", 32'($countones(bus.ch_ack)), 32'd1);
            for (int k = 0; k < NCH; k++) if (bus.ch_ack[k]) idx = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        int exp_rr;
        logic pend0;

        n_vec        = 0;
        n_err        = 0;
        rd_pipe[0]   = '0;
        rd_pipe[1]   = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h1FFF] = 8'h3C;

        bus.ch_req   = '0;
        bus.ch_we    = '0;
        bus.ch_addr  = '0;
        bus.ch_wdata = '0;

        // 1. Reset with every channel requesting
        rst = 1'b1;
        set_ch(0, 1'b1, 13'h0010, 8'h11);
        set_ch(1, 1'b1, 13'h0020, 8'h22);
        set_ch(2, 1'b1, 13'h0030, 8'h33);
        bus.ch_req = 3'b111;
        tick();
        tick();
        check_vec("rst_ack",  32'(bus.ch_ack),   32'h0);
        check_vec("rst_ce",   32'(bus.ram_ce),   32'h0);
        check_vec("rst_addr", 32'(bus.ram_addr), 32'h0);
        check_vec("rst_tst",  32'(bus.tst),      32'h0);
        rst = 1'b0;
        tick();
        check_vec("rst_first_tst",  32'(bus.tst),      32'h1);
        check_vec("rst_first_addr", 32'(bus.ram_addr), 32'h0010);
        wait_ack(idx, cyc);
        check_vec("rst_first_grant", 32'(idx), 32'd0);
        bus.ch_req = '0;
        tick();
        check_vec("rst_idle_ack", 32'(bus.ch_ack), 32'h0);

        // 2. Single write from channel 1
        set_ch(1, 1'b1, 13'h0123, 8'hA5);
        bus.ch_req = 3'b010;
        tick();
        check_vec("wr_ce",    32'(bus.ram_ce),    32'h1);
        check_vec("wr_we",    32'(bus.ram_we),    32'h1);
        check_vec("wr_addr",  32'(bus.ram_addr),  32'h0123);
        check_vec("wr_wdata", 32'(bus.ram_wdata), 32'hA5);
        check_vec("wr_ack_t1", 32'(bus.ch_ack),   32'h0);
        tick();
        check_vec("wr_ack_t2", 32'(bus.ch_ack),   32'h2);
        check_vec("wr_ce_t2",  32'(bus.ram_ce),   32'h0);
        bus.ch_req = '0;
        tick();
        check_vec("wr_ack_t3", 32'(bus.ch_ack),   32'h0);
        check_vec("wr_state_t3", 32'(bus.tst[1:0]), 32'h0);
        check_vec("wr_mem", 32'(mem[13'h0123]), 32'hA5);

        // 3. Single read from channel 2
        set_ch(2, 1'b0, 13'h1FFF, 8'h00);
        bus.ch_req = 3'b100;
        tick();
        check_vec("rd_ce_t1",   32'(bus.ram_ce),   32'h1);
        check_vec("rd_we_t1",   32'(bus.ram_we),   32'h0);
        check_vec("rd_addr_t1", 32'(bus.ram_addr), 32'h1FFF);
        tick();
        check_vec("rd_ce_t2",  32'(bus.ram_ce), 32'h0);
        check_vec("rd_ack_t2", 32'(bus.ch_ack), 32'h0);
        tick();
        check_vec("rd_ce_t3",  32'(bus.ram_ce), 32'h0);
        check_vec("rd_ack_t3", 32'(bus.ch_ack), 32'h0);
        tick();
        check_vec("rd_ce_t4",    32'(bus.ram_ce),   32'h0);
        check_vec("rd_ack_t4",   32'(bus.ch_ack),   32'h4);
        check_vec("rd_rdata_t4", 32'(bus.ch_rdata), 32'h3C);
        bus.ch_req = '0;
        tick();
        check_vec("rd_ack_t5",  32'(bus.ch_ack),   32'h0);
        check_vec("rd_hold_t5", 32'(bus.ch_rdata), 32'h3C);

`ifndef RAM_ARB_PRIO0_EN
        // 4. Fairness: all channels request continuously (writes)
        set_ch(0, 1'b1, 13'h0100, 8'h10);
        set_ch(1, 1'b1, 13'h0101, 8'h11);
        set_ch(2, 1'b1, 13'h0102, 8'h12);
        bus.ch_req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            wait_ack(idx, cyc);
            check_vec($sformatf("rr_order_%0d", n), 32'(idx), 32'(n % 3));
            check_vec($sformatf("rr_cycles_%0d", n), 32'(cyc), (n == 0) ? 32'd2 : 32'd3);
        end
        bus.ch_req = '0;
        tick();
`else
        // 5. Channel 0 priority over rotating channels 1 and 2
        set_ch(0, 1'b0, 13'h0200, 8'h00);
        set_ch(1, 1'b1, 13'h0201, 8'h21);
        set_ch(2, 1'b1, 13'h0202, 8'h22);
        bus.ch_req = 3'b110;
        exp_rr = 1;
        pend0  = 1'b0;
        for (int n = 0; n < 30; n++) begin
            wait_ack(idx, cyc);
            check_vec($sformatf("prio_order_%0d", n), 32'(idx), pend0 ? 32'd0 : 32'(exp_rr));
            if (idx == 0) begin
                pend0         = 1'b0;
                bus.ch_req[0] = 1'b0;
            end else begin
                exp_rr = (idx == 1) ? 2 : 1;
            end
            if (n % 10 == 4) begin
                pend0         = 1'b1;
                bus.ch_req[0] = 1'b1;
            end
        end
        bus.ch_req = '0;
        tick();
`endif

        // 6. Reset during the first WAIT cycle of a channel 0 read
        set_ch(0, 1'b0, 13'h1FFF, 8'h00);
        bus.ch_req = 3'b001;
        tick();
        check_vec("mrst_ce_issue", 32'(bus.ram_ce), 32'h1);
        tick();
        check_vec("mrst_in_wait", 32'(bus.tst[1:0]), 32'h2);
        rst = 1'b1;
        tick();
        check_vec("mrst_ce",    32'(bus.ram_ce),    32'h0);
        check_vec("mrst_ack",   32'(bus.ch_ack),    32'h0);
        check_vec("mrst_state", 32'(bus.tst[1:0]),  32'h0);
        rst        = 1'b0;
        bus.ch_req = '0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_vec($sformatf("mrst_noack_%0d", n), 32'(bus.ch_ack), 32'h0);
        end
        check_vec("mrst_idle", 32'(bus.tst[1:0]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arb_nch.md
Name: ram_arb_nch

Overview:
- Parametrised successor of the two-port frame-buffer FIFO/RAM controller.
- Arbitrates NCH requestor channels onto one external single-port synchronous SRAM, e.g. STN capture write, TFT scan read, host direct access, and a future second panel.
- Uses a per-channel req/ack handshake.
- Supports configurable address/data width, configurable RAM read latency and round-robin fairness.

Parameters:
- NCH, 3: number of requestor channels, legal range 2..8.
- AW, 13: RAM address width.
- DW, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles after the ram_ce cycle, legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ch_req  in  NCH  per-channel request, held high until ack
- ch_we  in  NCH  per-channel write (1) / read (0), stable while req high
- ch_addr  in  NCH*AW  per-channel address; channel k occupies bits [k*AW +: AW]
- ch_wdata  in  NCH*DW  per-channel write data; channel k occupies bits [k*DW +: DW]
- ch_ack  out  NCH  one-hot, one-cycle completion pulse
- ch_rdata  out  DW  read data, valid only in the cycle where the acked channel did a read
- ram_ce  out  1  RAM chip select, active-high
- ram_we  out  1  RAM write enable, active-high
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- tst  out  4  debug: {grant index[1:0], state[1:0]}

Behaviour:
- Single clock. Reset is synchronous, active-high.
- Outputs are registered except tst.
- Reset values:
  - ch_ack, ram_ce, ram_we = 0
  - ram_addr, ram_wdata, ch_rdata = 0
  - RR pointer = 0
  - state = IDLE
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Arbitrates only in this state.
  - If any ch_req is high, pick the winner g, latch g, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (one cycle):
  - ram_ce=1, ram_we=ch_we[g], ram_addr and ram_wdata taken from channel g.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter set to RD_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reaches 0, capture ram_rdata into ch_rdata and go to ACK.
  - ram_ce=0 throughout.
- ACK:
  - ch_ack[g]=1 for one cycle; RR pointer = (g+1) mod NCH; go to IDLE.
  - No arbitration in ACK, so a stale req seen in the ack cycle is never regranted.
- Latency, with req first high in IDLE at cycle t:
  - ram_ce is high at t+1.
  - Write: ack at t+2.
  - Read: ack at t+2+RD_LAT, ch_rdata valid in that same cycle.
- Throughput: 3 cycles per write, 3+RD_LAT cycles per read.
- Round-robin: scan from the RR pointer upward, wrapping at NCH-1 back to 0; the first asserted req wins.
- Simultaneous requests: resolved by the RR order; losers keep req high and are served in later rounds.
- Starvation bound: a continuously requesting channel waits at most NCH-1 transactions.
- ch_rdata holds its value between reads; consumers sample it only alongside ack.
- Requestor rules:
  - Deasserting req before ack is a protocol error. The latched transaction still completes and still acks.
  - After seeing ack, a requestor may keep req high for back-to-back transactions, which restart arbitration in IDLE.
- Reset mid-operation: at the next edge ram_ce drops, the in-flight transaction is discarded, and no ack is issued.
- When no grant is active, ram_addr and ram_wdata hold their last values, and ram_ce and ram_we are 0.

Optional Feature:
- Macro: RAM_ARB_PRIO0_EN.
- Defined: channel 0 (the TFT scan read) has absolute priority. It wins whenever it requests in IDLE, and it does not move the RR pointer. Channels 1..NCH-1 rotate round-robin among themselves.
- Undefined: pure round-robin across all channels.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3;
  - legal-range constants for NCH and RD_LAT;
  - the clog2 helper used for the grant-index width.
- Natural sub-module: rr_arbiter. It is combinational and takes req[NCH], the pointer and the priority-enable, and returns a one-hot grant plus the index. The FSM, registers and RAM muxing stay in ram_arb_nch.

Test Plan (NCH=3, AW=13, DW=8, RD_LAT=2):
1. Reset check: hold rst for 2 cycles with all ch_req=1. Required: ch_ack=0, ram_ce=0, ram_addr=0. The first grant after release goes to channel 0.
2. Single write: ch 1 writes 0xA5 to 0x0123 at cycle t. Required: ram_ce=1, ram_we=1, ram_addr=0x0123, ram_wdata=0xA5 at t+1; ch_ack=3'b010 at t+2 only.
3. Single read: ch 2 reads 0x1FFF, with the RAM model returning 0x3C two cycles after ce. Required: ch_ack=3'b100 and ch_rdata=0x3C at t+4; ram_ce low at t+2..t+4.
4. Fairness: all three channels hold req continuously. Required: ack order 0,1,2,0,1,2, and no channel is granted twice in a row.
5. RAM_ARB_PRIO0_EN: channels 1 and 2 request continuously and channel 0 pulses req every 10 transactions. Required: channel 0 is granted at the next IDLE each time; channels 1 and 2 keep alternating.
6. Mid-transaction reset: assert rst at the first WAIT cycle of a ch 0 read. Required: no ch_ack for that read, ram_ce=0 next cycle, and the FSM is in IDLE with tst[1:0]=0.
